// File: rtl/dma_fifo_fill_controller.sv
// ---------------------------------------------------------------------------
// dma_fifo_fill_controller
//
// Moves a programmed number of words from system memory into the SD host
// data FIFO write port. A start pulse latches the first address and the word
// count. For each word the controller:
//   1. issues a memory read request (REQ),
//   2. waits for FIFO space (PUSH),
//   3. pulses the FIFO write strobe and waits for the FIFO acknowledge
//      (WAIT_ACK).
// It then finishes with a one-cycle DONE pulse. Missing acknowledges time
// out into a sticky error. An abort stops the transfer early.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   start, abort          transfer control
//   base_addr, word_count transfer setup, latched on an accepted start
//   busy, done, error     status (done is a single-cycle pulse)
//   words_moved           words acknowledged by the FIFO in this/last transfer
//   mem_req/addr/ack/rdata  simple req/ack memory read bus
//   fifo_data/write/full/ack  FIFO write port
//
// Every output comes from a register or is a decode of the state register,
// so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module dma_fifo_fill_controller #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  words_moved,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_write,
  input  logic              fifo_full,
  input  logic              fifo_ack
);

  // The wait counter only has to reach TIMEOUT-1: it is 0 in the first
  // cycle of a state, so TIMEOUT-1 marks the TIMEOUT-th cycle.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_PUSH,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  state_t             state_reg;
  logic [ADDR_W-1:0]  cur_addr_reg;
  logic [LEN_W-1:0]   remaining_reg;
  logic [DATA_W-1:0]  data_reg;
  logic [CNT_W-1:0]   wait_cnt_reg;
  logic [LEN_W-1:0]   words_moved_reg;
  logic               error_reg;
  logic               write_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      cur_addr_reg    <= '0;
      remaining_reg   <= '0;
      data_reg        <= '0;
      wait_cnt_reg    <= '0;
      words_moved_reg <= '0;
      error_reg       <= 1'b0;
      write_reg       <= 1'b0;
    end else begin
      // The FIFO write strobe is a single-cycle pulse. It is raised only on
      // the PUSH -> WAIT_ACK transition.
      write_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            words_moved_reg <= '0;
            error_reg       <= 1'b0;
            if (word_count != '0) begin
              cur_addr_reg  <= base_addr;
              remaining_reg <= word_count;
              wait_cnt_reg  <= '0;
              state_reg     <= S_REQ;
            end else begin
              state_reg <= S_DONE;
            end
          end
        end

        S_REQ: begin
          if (abort) begin
            state_reg <= S_DONE;
          end else if (mem_ack) begin
            data_reg  <= mem_rdata;
            state_reg <= S_PUSH;
          end else if (wait_cnt_reg == CNT_LAST) begin
            error_reg <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end

        // PUSH waits on FIFO space indefinitely; only abort can leave early.
        S_PUSH: begin
          if (abort) begin
            state_reg <= S_DONE;
          end else if (!fifo_full) begin
            write_reg    <= 1'b1;
            wait_cnt_reg <= '0;
            state_reg    <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          if (abort) begin
            state_reg <= S_DONE;
          end else if (fifo_ack) begin
            words_moved_reg <= words_moved_reg + 1'b1;
            cur_addr_reg    <= cur_addr_reg + ADDR_STEP;
            remaining_reg   <= remaining_reg - 1'b1;
            wait_cnt_reg    <= '0;
            state_reg       <= (remaining_reg == LEN_W'(1)) ? S_DONE : S_REQ;
          end else if (wait_cnt_reg == CNT_LAST) begin
            error_reg <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_reg != S_IDLE);
  assign done        = (state_reg == S_DONE);
  assign mem_req     = (state_reg == S_REQ);
  assign mem_addr    = cur_addr_reg;
  assign fifo_data   = data_reg;
  assign fifo_write  = write_reg;
  assign words_moved = words_moved_reg;
  assign error       = error_reg;

endmodule
